// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Desc     : Shared constants, FSM state type and lane helpers for the
//            load/store front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mem_access_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LD_REQ   = 3'd1,
        ST_LD_DATA  = 3'd2,
        ST_ST_WORD  = 3'd3,
        ST_RMW_REQ  = 3'd4,
        ST_RMW_DATA = 3'd5,
        ST_RMW_WR   = 3'd6,
        ST_RESP     = 3'd7
    } state_t;

    // Memory write lanes are big-endian relative to the read lanes; swapping
    // keeps the logical view little-endian.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_shifter.sv
// ============================================================================
// Module   : mem_lane_shifter
// Desc     : Combinational load extraction/extension and sub-word store merge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_lane_shifter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused_wdata;

    assign w_unused_wdata = ^wdata[31:16];

    always_comb begin
        w_byte    = rdata[{offset, 3'b000} +: 8];
        w_half    = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        merged    = rdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{~zero_ext & w_byte[7]}}, w_byte};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{~zero_ext & w_half[15]}}, w_half};
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data = rdata;
                merged    = rdata;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Desc     : Single-outstanding load/store sequencer in front of a word-ported
//            data memory, with sub-word extraction and read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_zero_ext;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic [31:0] r_resp_data;
    logic        r_err;

    logic        w_accept;
    logic        w_oor;
    logic        w_err;
    logic        w_rd;
    logic        w_wr;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = req_valid & (r_state == ST_IDLE);
    assign w_oor    = (req_addr >> ADDR_W) != 32'd0;
    assign w_err    = (req_size == 2'b11)
                    | ((req_size == SIZE_HALF) & req_addr[0])
                    | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
                    | w_oor;

    mem_lane_shifter u_lane_shifter (
        .rdata     (mem_rdata),
        .offset    (r_addr[1:0]),
        .size      (r_size),
        .zero_ext  (r_zero_ext),
        .wdata     (r_wdata),
        .load_data (w_load),
        .merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_size      <= '0;
            r_zero_ext  <= 1'b0;
            r_wdata     <= '0;
            r_merged    <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr      <= req_addr;
                r_size      <= req_size;
                r_zero_ext  <= req_unsigned;
                r_wdata     <= req_wdata;
                r_err       <= w_err;
                r_resp_data <= '0;
            end
            if (r_state == ST_LD_DATA) begin
                r_resp_data <= w_load;
            end
            if (r_state == ST_RMW_DATA) begin
                r_merged <= w_merged;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_rd      = 1'b0;
        w_wr      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_next = ST_RESP;
                    end else if (!req_write) begin
                        w_next = ST_LD_REQ;
                    end else if (req_size == SIZE_WORD) begin
                        w_next = ST_ST_WORD;
                    end else begin
                        w_next = ST_RMW_REQ;
                    end
                end
            end
            ST_LD_REQ: begin
                w_rd     = 1'b1;
                mem_addr = {r_addr[31:2], 2'b00};
                w_next   = ST_LD_DATA;
            end
            ST_LD_DATA: begin
                mem_addr = {r_addr[31:2], 2'b00};
                w_next   = ST_RESP;
            end
            ST_ST_WORD: begin
                w_wr      = 1'b1;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = byte_swap32(r_wdata);
                w_next    = ST_RESP;
            end
            ST_RMW_REQ: begin
                w_rd     = 1'b1;
                mem_addr = {r_addr[31:2], 2'b00};
                w_next   = ST_RMW_DATA;
            end
            ST_RMW_DATA: begin
                mem_addr = {r_addr[31:2], 2'b00};
                w_next   = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                w_wr      = 1'b1;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = byte_swap32(r_merged);
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Gating with rst keeps a reset during RMW from corrupting memory.
    assign mem_read   = w_rd & ~rst;
    assign mem_write  = w_wr & ~rst;
    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_data  = resp_valid ? r_resp_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Desc     : Randomized bench with a byte-array reference model of the
//            logical (little-endian) memory and a per-cycle response checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata)
    );

    // Physical memory (bus lane convention) and logical reference copy.
    logic [7:0] mem_b [256];
    logic [7:0] ref_b [256];

    always @(posedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < 4; k++)
                mem_b[{mem_addr[7:2], 2'b00} + k] <= mem_wdata[31 - 8*k -: 8];
        end
        if (mem_read) begin
            mem_rdata <= {mem_b[{mem_addr[7:2], 2'b11}], mem_b[{mem_addr[7:2], 2'b10}],
                          mem_b[{mem_addr[7:2], 2'b01}], mem_b[{mem_addr[7:2], 2'b00}]};
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        chk_on = 1'b0;
    int          n_rd, n_wr, rd_cyc, wr_cyc;
    logic [31:0] rd_addr, wr_addr, last_wd, last_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare process
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
            if (mem_read) begin
                n_rd++; rd_cyc = cyc; rd_addr = mem_addr;
            end
            if (mem_write) begin
                n_wr++; wr_cyc = cyc; wr_addr = mem_addr; last_wd = mem_wdata;
            end
            if (req_ready || resp_valid)
                chk("idle_bus_zero", mem_addr | mem_wdata, 32'd0);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("resp_valid", {31'd0, resp_valid}, 32'd1);
                chk("resp_data", resp_data, q[0].data);
                chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                last_data = resp_data;
                void'(q.pop_front());
            end else begin
                chk("resp_valid_quiet", {31'd0, resp_valid}, 32'd0);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int          n, acc, lat;
        logic        err;
        logic [7:0]  lo, base;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d, exp_wd;
        exp_t        e;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_write = 1'($urandom); req_unsigned = 1'($urandom);
        n_rd = 0; n_wr = 0;

        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (a[31:8] != 24'd0);
        lo = a[7:0];
        base = {lo[7:2], 2'b00};
        d = 32'd0;
        exp_wd = 32'd0;
        if (err)                 lat = 1;
        else if (!wr)            lat = 3;
        else if (sz == 2'b10)    lat = 2;
        else                     lat = 4;
        if (!err && !wr) begin
            case (sz)
                2'b00: begin b = ref_b[lo]; d = uns ? {24'd0, b} : {{24{b[7]}}, b}; end
                2'b01: begin h = {ref_b[lo + 1], ref_b[lo]}; d = uns ? {16'd0, h} : {{16{h[15]}}, h}; end
                default: d = {ref_b[lo + 3], ref_b[lo + 2], ref_b[lo + 1], ref_b[lo]};
            endcase
        end
        if (!err && wr) begin
            ref_b[lo] = wd[7:0];
            if (sz != 2'b00) ref_b[lo + 1] = wd[15:8];
            if (sz == 2'b10) begin ref_b[lo + 2] = wd[23:16]; ref_b[lo + 3] = wd[31:24]; end
            exp_wd = {ref_b[base], ref_b[base + 1], ref_b[base + 2], ref_b[base + 3]};
        end
        e.due = acc + lat - 1; e.data = d; e.err = err;
        q.push_back(e);

        repeat (lat) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            chk("resp_missing", q.size(), 32'd0);
            q.delete();
        end
        chk("n_mem_read", n_rd, (!err && (!wr || sz != 2'b10)) ? 1 : 0);
        chk("n_mem_write", n_wr, (!err && wr) ? 1 : 0);
        if (!err && (!wr || sz != 2'b10)) begin
            chk("read_cycle", rd_cyc, acc);
            chk("read_addr", rd_addr, {a[31:2], 2'b00});
        end
        if (!err && wr) begin
            chk("write_cycle", wr_cyc, (sz == 2'b10) ? acc : acc + 2);
            chk("write_addr", wr_addr, {a[31:2], 2'b00});
            chk("write_data", last_wd, exp_wd);
        end
    endtask

    task automatic rst_abort(input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_wr = 0;
        @(posedge clk); #1;   // now in the merge cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_write", n_wr, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        for (int i = 20; i < 24; i++) mem_b[i] = 8'h55;
        for (int i = 40; i < 44; i++) mem_b[i] = 8'hAA;
        for (int i = 0; i < 256; i++) ref_b[i] = mem_b[i];
        mem_rdata = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        n_rd = 0; n_wr = 0; rd_cyc = 0; wr_cyc = 0;
        rd_addr = 0; wr_addr = 0; last_wd = 0; last_data = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp", {resp_data[30:0] | {30'd0, resp_err}, resp_valid}, 32'd0);
        chk("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
        chk_on = 1'b1;

        do_req(1'b0, 2'b10, 1'b0, 32'd20, 32'd0);
        chk("pin_ld_w20", last_data, 32'h55555555);
        do_req(1'b0, 2'b00, 1'b1, 32'd40, 32'd0);
        chk("pin_ld_bu40", last_data, 32'h000000AA);
        do_req(1'b0, 2'b00, 1'b0, 32'd40, 32'd0);
        chk("pin_ld_bs40", last_data, 32'hFFFFFFAA);
        do_req(1'b0, 2'b01, 1'b0, 32'd42, 32'd0);
        chk("pin_ld_hs42", last_data, 32'hFFFFAAAA);
        do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h11223344);
        chk("pin_st_w8_bus", last_wd, 32'h44332211);
        do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
        chk("pin_ld_w8", last_data, 32'h11223344);
        do_req(1'b0, 2'b00, 1'b1, 32'd8, 32'd0);
        chk("pin_ld_b8", last_data, 32'h00000044);
        do_req(1'b0, 2'b00, 1'b1, 32'd11, 32'd0);
        chk("pin_ld_b11", last_data, 32'h00000011);
        do_req(1'b1, 2'b00, 1'b0, 32'd21, 32'h1234567E);
        chk("pin_st_b21_bus", last_wd, 32'h557E5555);
        do_req(1'b0, 2'b10, 1'b0, 32'd20, 32'd0);
        chk("pin_ld_w20_after", last_data, 32'h55557E55);

        do_req(1'b0, 2'b01, 1'b0, 32'h29, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h2A, 32'hDEADBEEF);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);

        rst_abort(32'd40, 32'h000000FF);
        do_req(1'b0, 2'b10, 1'b0, 32'd40, 32'd0);
        chk("pin_ld_w40_after_abort", last_data, 32'hAAAAAAAA);

        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (r == 0) begin
                a = $urandom | 32'h100;
            end else begin
                a = 32'($urandom_range(0, 255));
                if (r < 7 && sz == 2'b01) a[0] = 1'b0;
                if (r < 7 && sz == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end sitting directly upstream of the data memory (256-byte, word-ported, 1-cycle registered read, posedge write).
- Accepts one load/store request at a time from the pipeline's MEM stage.
- Sequences the memory's read/write strobes.
- Performs byte/halfword extraction with sign/zero extension.
- Implements sub-word stores as read-modify-write.
- Rejects misaligned or out-of-range accesses without touching memory.

Parameters:
ADDR_W, 8, implemented byte-address width of the data memory (any req_addr bit at or above ADDR_W set = out of range)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse (loads and stores)
resp_data  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, out of range or illegal size
busy  output  1  high in any state other than IDLE
mem_addr  output  32  word-aligned byte address to memory ({req_addr[31:2],2'b00})
mem_wdata  output  32  memory write data
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_rdata  input  32  memory read data, valid the cycle after mem_read is high

Behaviour:
- Memory lane convention (fixed):
  - Read: mem_rdata[8k+7:8k] = byte at mem_addr+k.
  - Write: mem_wdata[31:24] -> byte mem_addr+0 ... mem_wdata[7:0] -> mem_addr+3.
  - The unit byte-reverses every write word (mem_wdata = {w[7:0],w[15:8],w[23:16],w[31:24]}), so the logical view is little-endian and a stored word reads back unchanged.
- Accept: req_valid & req_ready at a rising edge. The unit registers addr, size, write, unsigned and wdata.
- States: IDLE, LD_REQ, LD_DATA, ST_WORD, RMW_REQ, RMW_DATA, RMW_WR, RESP.
- Transitions from IDLE on accept:
  - Error (size 11, half with addr[0]=1, word with addr[1:0]!=0, out of range) -> RESP with err.
  - Load -> LD_REQ.
  - Word store -> ST_WORD.
  - Byte/half store -> RMW_REQ.
- Load path: LD_REQ (mem_read=1) -> LD_DATA (extract from mem_rdata, register into resp_data) -> RESP. resp_valid is high in the 3rd cycle after the accept edge.
- Word store path: ST_WORD (mem_write=1, mem_wdata=swap(wdata)) -> RESP. resp_valid is high in the 2nd cycle after accept.
- Sub-word store path: RMW_REQ (mem_read=1) -> RMW_DATA (merge the new byte/half into lane addr[1:0] of mem_rdata, register the result) -> RMW_WR (mem_write=1, mem_wdata=swap(merged)) -> RESP. resp_valid is high in the 4th cycle after accept.
- Error path: resp_valid + resp_err are high in the 1st cycle after accept; mem_read and mem_write never assert.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted no earlier than the cycle after RESP.
- Extraction:
  - byte = lane addr[1:0].
  - half = rdata[15:0] if addr[1]=0, else rdata[31:16].
  - Extend to 32 bits per req_unsigned.
  - Word ignores req_unsigned.
- mem_read and mem_write are decoded from state and gated low whenever rst=1. They are never high together. mem_addr and mem_wdata are 0 in IDLE and RESP.
- Reset: the next edge forces IDLE and clears the captured registers. req_ready=1 (after reset), busy=0, resp_valid=0, resp_data=0, resp_err=0, mem_* outputs=0. An in-flight request is dropped without a response. A reset asserted during RMW_DATA or RMW_WR prevents the write.
- req_valid while busy is ignored; the requester holds it.

Decomposition:
- Package mem_access_pkg contains:
  - SIZE_BYTE, SIZE_HALF, SIZE_WORD constants.
  - State enum.
  - ADDR_W default.
  - byte_swap32 function.
- One combinational sub-module, mem_lane_shifter:
  - Inputs: rdata, offset, size, unsigned, wdata.
  - Outputs: extracted load value and merged store word.

Test Plan:
- Word load from addr 20 (memory preset 0x55555555) -> mem_read high in cycle 1 after accept; resp_valid in cycle 3; resp_data=0x55555555; resp_err=0.
- Byte load from addr 40 (preset 0xaaaaaaaa): unsigned -> 0x000000AA; signed -> 0xFFFFFFAA. Half load signed from addr 42 -> 0xFFFFAAAA.
- Word store 0x11223344 to addr 8 -> mem_wdata=0x44332211 with mem_write for exactly one cycle. Then word load 8 -> 0x11223344; byte load 8 -> 0x00000044; byte load 11 -> 0x00000011.
- Byte store 0x7E to addr 21 over 0x55555555 -> sequence mem_read, then mem_write with mem_wdata=0x557E5555. Then word load 20 -> 0x55557E55; resp_valid in cycle 4 after the store accept.
- Half load at addr 0x29, word store at 0x2A, size 11, addr 0x100 -> each gives resp_valid+resp_err=1 one cycle after accept, resp_data=0, no mem_read/mem_write.
- Byte store 0xFF to addr 40 with rst pulsed during RMW_DATA -> no mem_write, no resp_valid, req_ready=1 next cycle. Word load 40 -> 0xaaaaaaaa.
